// File: rtl/spectrum_band_accumulator.sv
// -----------------------------------------------------------------------------
// spectrum_band_accumulator
//
// Groups the per-bin FFT magnitude stream into 8 bands of (1 << LOG2_BPB)
// consecutive bins. Each band is averaged and saturated to 12 bits. The result
// is then peak-fall smoothed: a rising band jumps straight up, and a falling
// band drops by at most DECAY per frame. All 8 bands are published together
// with a one-cycle valid strobe.
//
// Ports
//   clk                  clock
//   rst_n                asynchronous active-low reset
//   bin_valid            bin_mag / bin_last valid this cycle
//   bin_ready            block accepts a bin (low only during the publish cycle)
//   bin_mag[15:0]        unsigned bin magnitude
//   bin_last             final bin of the FFT frame
//   spectrum_data_packed band k at [12k+11:12k], band 0 = lowest frequency
//   spectrum_valid       one-cycle pulse when spectrum_data_packed was updated
//   frame_err            one-cycle pulse on a short or long frame
// -----------------------------------------------------------------------------
module spectrum_band_accumulator #(
   parameter int LOG2_BPB = 3,
   parameter int DECAY    = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bin_valid,
   output logic        bin_ready,
   input  logic [15:0] bin_mag,
   input  logic        bin_last,
   output logic [95:0] spectrum_data_packed,
   output logic        spectrum_valid,
   output logic        frame_err
);

   localparam int IDX_W  = LOG2_BPB + 3;
   localparam int ACC_W  = 16 + LOG2_BPB;
   localparam int N_BINS = 8 << LOG2_BPB;

   localparam logic [IDX_W-1:0] BAND_MASK = IDX_W'((1 << LOG2_BPB) - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_BINS - 1);
   localparam logic [ACC_W-1:0] SAT_MAX   = ACC_W'(4095);
   localparam logic [11:0]      DECAY_Q   = 12'(DECAY);

   typedef enum logic [1:0] {
      ST_ACCUM   = 2'd0,
      ST_PUBLISH = 2'd1,
      ST_RESYNC  = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic [IDX_W-1:0]  bin_idx_reg;
   logic [ACC_W-1:0]  acc_reg;
   logic              valid_reg;
   logic              err_reg;

   logic              transfer;
   logic              accum_en;
   logic              good_frame;
   logic              short_frame;
   logic              long_frame;
   logic              band_end;
   logic              frame_end;
   logic [2:0]        band_idx;
   logic [ACC_W-1:0]  acc_sum;
   logic [ACC_W-1:0]  avg_full;
   logic [11:0]       avg_sat;

   assign bin_ready = (state_reg != ST_PUBLISH);
   assign transfer  = bin_valid && bin_ready;

   // The accumulator is wide enough for a full band of 0xFFFF bins, so the sum
   // itself never wraps; saturation is applied only to the averaged value.
   assign acc_sum   = acc_reg + ACC_W'(bin_mag);
   assign avg_full  = acc_sum >> LOG2_BPB;
   assign avg_sat   = (avg_full > SAT_MAX) ? 12'hFFF : avg_full[11:0];

   assign band_end  = ((bin_idx_reg & BAND_MASK) == BAND_MASK);
   assign frame_end = (bin_idx_reg == LAST_IDX);
   assign band_idx  = 3'(bin_idx_reg >> LOG2_BPB);

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_ACCUM;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      accum_en    = 1'b0;
      good_frame  = 1'b0;
      short_frame = 1'b0;
      long_frame  = 1'b0;
      case (state_reg)
         ST_ACCUM: begin
            if (transfer) begin
               accum_en = 1'b1;
               if (bin_last && frame_end) begin
                  good_frame = 1'b1;
                  state_next = ST_PUBLISH;
               end else if (bin_last) begin
                  short_frame = 1'b1;
               end else if (frame_end) begin
                  // Frame ran past N_BINS: drop everything up to the next bin_last.
                  long_frame = 1'b1;
                  state_next = ST_RESYNC;
               end
            end
         end
         ST_RESYNC: begin
            if (transfer && bin_last) begin
               state_next = ST_ACCUM;
            end
         end
         ST_PUBLISH: begin
            state_next = ST_ACCUM;
         end
         default: begin
            state_next = ST_ACCUM;
         end
      endcase
   end

   // ------------------------------------------------------- bin bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_idx_reg <= '0;
         acc_reg     <= '0;
         valid_reg   <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         err_reg   <= short_frame || long_frame;
         valid_reg <= (state_reg == ST_PUBLISH);

         if (accum_en) begin
            if (band_end || short_frame || long_frame) begin
               acc_reg <= '0;
            end else begin
               acc_reg <= acc_sum;
            end

            if (good_frame || short_frame || long_frame) begin
               bin_idx_reg <= '0;
            end else begin
               bin_idx_reg <= bin_idx_reg + IDX_W'(1);
            end
         end

         if (state_reg == ST_RESYNC && transfer && bin_last) begin
            bin_idx_reg <= '0;
         end
      end
   end

   // ------------------------------------------------- per-band stage + output
   // A short or long frame may leave partially written stage entries behind;
   // that is harmless because every good frame rewrites all 8 entries before
   // it reaches PUBLISH.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : gen_band
         logic [11:0] stage_reg;
         logic [11:0] field_reg;
         logic [11:0] field_decayed;
         logic [11:0] field_next;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               stage_reg <= '0;
            end else if (accum_en && band_end && band_idx == 3'(gi)) begin
               stage_reg <= avg_sat;
            end
         end

         // old - DECAY, floored at zero so a small value can never wrap high.
         assign field_decayed = (field_reg > DECAY_Q) ? (field_reg - DECAY_Q) : 12'd0;

         always_comb begin
            field_next = stage_reg;
            if (stage_reg < field_reg && field_decayed > stage_reg) begin
               field_next = field_decayed;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               field_reg <= '0;
            end else if (state_reg == ST_PUBLISH) begin
               field_reg <= field_next;
            end
         end

         assign spectrum_data_packed[12*gi +: 12] = field_reg;
      end
   endgenerate

   assign spectrum_valid = valid_reg;
   assign frame_err      = err_reg;

endmodule

// File: tb/tb_spectrum_band_accumulator.sv
// -----------------------------------------------------------------------------
// tb_spectrum_band_accumulator
//
// Directed bench for spectrum_band_accumulator with default parameters
// (64 bins per frame, 8 bins per band, DECAY = 16). Every frame drives each
// band with a known average, and the expected published fields are computed
// by hand from the averaging, saturation and peak-fall rules.
// -----------------------------------------------------------------------------
module tb_spectrum_band_accumulator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        bin_valid;
   logic        bin_ready;
   logic [15:0] bin_mag;
   logic        bin_last;
   logic [95:0] spectrum_data_packed;
   logic        spectrum_valid;
   logic        frame_err;

   int checks   = 0;
   int failures = 0;

   int valid_cnt     = 0;
   int err_cnt       = 0;
   int ready_low_cnt = 0;

   logic [15:0] band_vals [8];
   logic [11:0] exp_vals  [8];

   spectrum_band_accumulator #(
      .LOG2_BPB (3),
      .DECAY    (16)
   ) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .bin_valid            (bin_valid),
      .bin_ready            (bin_ready),
      .bin_mag              (bin_mag),
      .bin_last             (bin_last),
      .spectrum_data_packed (spectrum_data_packed),
      .spectrum_valid       (spectrum_valid),
      .frame_err            (frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (spectrum_valid) valid_cnt++;
      if (frame_err)      err_cnt++;
      if (!bin_ready)     ready_low_cnt++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic check_fields(input string tag);
      for (int k = 0; k < 8; k++) begin
         check_eq($sformatf("%s_band%0d", tag, k),
                  32'(spectrum_data_packed[12*k +: 12]), 32'(exp_vals[k]));
      end
   endtask

   // Presents one bin and holds it until the block accepts it. Returns at the
   // falling edge after the accepting rising edge. While idle the data lines
   // carry garbage to show they are ignored without a transfer.
   task automatic send_bin(input logic [15:0] mag, input logic last, input bit throttle);
      bit ok;
      int tries;
      if (throttle) begin
         for (int k = 0; k < 4 && $urandom_range(1) == 0; k++) begin
            bin_valid = 1'b0;
            bin_mag   = 16'hFFFF;
            bin_last  = 1'b1;
            @(negedge clk);
         end
      end
      bin_valid = 1'b1;
      bin_mag   = mag;
      bin_last  = last;
      ok        = 1'b0;
      tries     = 0;
      while (!ok && tries < 8) begin
         ok = bin_ready;
         @(posedge clk);
         @(negedge clk);
         tries++;
      end
      bin_valid = 1'b0;
      bin_mag   = 16'hFFFF;
      bin_last  = 1'b1;
      if (!ok) check_eq("accept_timeout", 32'd0, 32'd1);
   endtask

   // Band-k bin i-th magnitude. With ripple the 8 bins are v-7, v-5 .. v+7,
   // whose average is still exactly v.
   function automatic logic [15:0] bin_value(input int i, input bit ripple);
      int v;
      v = int'(band_vals[(i >> 3) & 7]);
      if (ripple && v >= 7 && v <= 65528) v = v - 7 + 2 * (i % 8);
      return 16'(v);
   endfunction

   task automatic send_bins(input int nbins, input bit last_on_end, input bit throttle,
                            input bit ripple);
      for (int i = 0; i < nbins; i++) begin
         send_bin(bin_value(i, ripple), last_on_end && (i == nbins - 1), throttle);
      end
   endtask

   task automatic settle();
      @(negedge clk);
      @(negedge clk);
      #1;
   endtask

   // Full good frame, then checks publish latency, the ready bubble and fields.
   task automatic good_frame(input string tag, input bit throttle, input bit ripple);
      int v0, r0;
      #1;
      v0 = valid_cnt;
      r0 = ready_low_cnt;
      send_bins(64, 1'b1, throttle, ripple);
      check_eq({tag, "_ready_bubble"}, 32'(bin_ready), 32'd0);
      check_eq({tag, "_valid_early"}, 32'(spectrum_valid), 32'd0);
      @(negedge clk);
      check_eq({tag, "_valid_pulse"}, 32'(spectrum_valid), 32'd1);
      check_eq({tag, "_ready_back"}, 32'(bin_ready), 32'd1);
      check_fields(tag);
      @(negedge clk);
      check_eq({tag, "_valid_drop"}, 32'(spectrum_valid), 32'd0);
      #1;
      check_eq({tag, "_valid_count"}, 32'(valid_cnt - v0), 32'd1);
      check_eq({tag, "_ready_low_count"}, 32'(ready_low_cnt - r0), 32'd1);
      $display("frame %s published", tag);
   endtask

   task automatic do_reset();
      bin_valid = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic set_all(input logic [15:0] v, input logic [11:0] e);
      for (int k = 0; k < 8; k++) begin
         band_vals[k] = v;
         exp_vals[k]  = e;
      end
   endtask

   initial begin
      int v0, e0;
      rst_n     = 1'b0;
      bin_valid = 1'b0;
      bin_mag   = '0;
      bin_last  = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_data", 32'(spectrum_data_packed == 96'd0), 32'd1);
      check_eq("rst_valid", 32'(spectrum_valid), 32'd0);
      check_eq("rst_err", 32'(frame_err), 32'd0);
      check_eq("rst_ready", 32'(bin_ready), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // All bins 800 -> every band 800.
      set_all(16'd800, 12'd800);
      good_frame("flat800", 1'b0, 1'b0);

      // Band 3 saturates, others 100 (from a cleared output).
      do_reset();
      set_all(16'd100, 12'd100);
      band_vals[3] = 16'hFFFF;
      exp_vals[3]  = 12'd4095;
      good_frame("saturate", 1'b0, 1'b1);

      // Peak-fall smoothing.
      do_reset();
      set_all(16'd1000, 12'd1000);
      good_frame("decayA", 1'b0, 1'b1);
      set_all(16'd500, 12'd984);
      good_frame("decayB", 1'b0, 1'b1);
      set_all(16'd990, 12'd990);
      good_frame("decayC", 1'b0, 1'b1);
      do_reset();
      set_all(16'd10, 12'd10);
      good_frame("from10", 1'b0, 1'b1);
      set_all(16'd0, 12'd0);
      good_frame("floor0", 1'b0, 1'b0);

      // Short frame: bin_last on bin 40.
      set_all(16'd300, 12'd300);
      good_frame("pre_short", 1'b0, 1'b1);
      #1;
      v0 = valid_cnt;
      e0 = err_cnt;
      set_all(16'd50, 12'd300);
      send_bins(41, 1'b1, 1'b0, 1'b1);
      check_eq("short_err_pulse", 32'(frame_err), 32'd1);
      settle();
      check_eq("short_err_count", 32'(err_cnt - e0), 32'd1);
      check_eq("short_no_valid", 32'(valid_cnt - v0), 32'd0);
      check_fields("short_hold");
      $display("short frame checked");
      set_all(16'd400, 12'd400);
      good_frame("post_short", 1'b0, 1'b1);

      // Long frame: 64 bins without bin_last, then 5 resync bins.
      #1;
      v0 = valid_cnt;
      e0 = err_cnt;
      set_all(16'd700, 12'd400);
      send_bins(64, 1'b0, 1'b0, 1'b1);
      check_eq("long_err_pulse", 32'(frame_err), 32'd1);
      send_bins(5, 1'b1, 1'b0, 1'b0);
      settle();
      check_eq("long_err_count", 32'(err_cnt - e0), 32'd1);
      check_eq("long_no_valid", 32'(valid_cnt - v0), 32'd0);
      check_fields("long_hold");
      $display("long frame + resync checked");
      set_all(16'd600, 12'd600);
      good_frame("post_long", 1'b0, 1'b1);

      // Throttled partial frame, asynchronous reset at bin 20.
      #1;
      v0 = valid_cnt;
      set_all(16'd900, 12'd0);
      send_bins(20, 1'b0, 1'b1, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_data", 32'(spectrum_data_packed == 96'd0), 32'd1);
      check_eq("async_rst_ready", 32'(bin_ready), 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      settle();
      check_eq("async_rst_no_valid", 32'(valid_cnt - v0), 32'd0);
      $display("mid-frame reset checked");
      for (int k = 0; k < 8; k++) begin
         band_vals[k] = 16'(100 * (k + 1));
         exp_vals[k]  = 12'(100 * (k + 1));
      end
      good_frame("throttled", 1'b1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=1 expected=0");
      $fatal(1, "timeout");
   end

endmodule
